// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-side memory port.
//   WORD_W          memory word / address width
//   MEM_DEPTH_DEF   default number of implemented words
//   STARVE_MAX_DEF  default D-wins-in-a-row limit before IF is forced through
package cpu_mem_pkg;

  localparam int unsigned WORD_W         = 16;
  localparam int unsigned MEM_DEPTH_DEF  = 1024;
  localparam int unsigned STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Request selected by arbitration, as latched on the acceptance edge.
  typedef struct packed {
    owner_e              owner;
    logic                we;
    logic                oor;
    logic [WORD_W-1:0]   addr;
    logic [WORD_W-1:0]   wdata;
  } req_t;

  // Counter width able to hold 0..max.
  function automatic int unsigned starve_cnt_w(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  function automatic logic addr_out_of_range(input logic [WORD_W-1:0] a,
                                             input int unsigned       depth);
    return 32'(a) >= depth;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between IF and D plus the saturating starvation counter.
//   clk_i, rst_ni   clock, async active-low reset
//   idle_i          arbiter can accept a request this cycle
//   if_req_i        IF requesting
//   d_req_i         D requesting
//   if_win_c_o      IF accepted this cycle (combinational)
//   d_win_c_o       D accepted this cycle (combinational)
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter  int unsigned STARVE_MAX = STARVE_MAX_DEF,
  localparam int unsigned CNT_W      = starve_cnt_w(STARVE_MAX)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_win_c_o,
  output logic d_win_c_o
);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             at_max_c;

  // D normally wins ties; once IF has been passed over STARVE_MAX times it wins.
  always_comb begin
    at_max_c   = (starve_q == CNT_W'(STARVE_MAX));
    if_win_c_o = idle_i & if_req_i & (~d_req_i | at_max_c);
    d_win_c_o  = idle_i & d_req_i & ~(if_req_i & at_max_c);
  end

  // Counts consecutive D wins that left IF waiting.
  always_comb begin
    starve_d = starve_q;
    if (d_win_c_o) begin
      if (!if_req_i)     starve_d = '0;
      else if (at_max_c) starve_d = starve_q;
      else               starve_d = starve_q + CNT_W'(1);
    end else if (if_win_c_o) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and D loads/stores onto the single-port word memory,
// one transaction in flight, and routes the response back to the winner.
//   CLK, reset                      clock, async active-low reset
//   if_req/if_addr                  IF read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata       IF accept (comb), response pulse, data
//   d_req/d_we/d_addr/d_wdata       D request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata/d_err    D accept (comb), response pulse, data, range error
//   MemRead/MemWrite/ADDR/Data_in   registered memory command
//   Data_out                        memory read data, valid in RESP
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [WORD_W-1:0] ADDR,
  output logic [WORD_W-1:0] Data_in,
  input  logic [WORD_W-1:0] Data_out
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_in_q, data_in_d;

  logic              idle_c;
  logic              if_win_c, d_win_c;
  req_t              sel_c;
  logic              resp_c;

  assign idle_c = (state_q == ST_IDLE);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i      (CLK),
    .rst_ni     (reset),
    .idle_i     (idle_c),
    .if_req_i   (if_req),
    .d_req_i    (d_req),
    .if_win_c_o (if_win_c),
    .d_win_c_o  (d_win_c)
  );

  // Request of whichever side wins; IF is always a read with no write data.
  always_comb begin
    sel_c.owner = d_win_c ? OWN_D : OWN_IF;
    sel_c.we    = d_win_c & d_we;
    sel_c.addr  = d_win_c ? d_addr : if_addr;
    sel_c.wdata = d_win_c ? d_wdata : '0;
    sel_c.oor   = addr_out_of_range(sel_c.addr, MEM_DEPTH);
  end

  // Next-state and command logic: IDLE accepts, CMD presents one cycle, RESP returns.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    oor_d       = oor_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;

    case (state_q)
      ST_IDLE: begin
        if (if_win_c || d_win_c) begin
          owner_d     = sel_c.owner;
          we_d        = sel_c.we;
          oor_d       = sel_c.oor;
          addr_d      = sel_c.addr;
          // Out-of-range requests never reach the memory strobes.
          mem_read_d  = ~sel_c.oor & ~sel_c.we;
          mem_write_d = ~sel_c.oor & sel_c.we;
          if (!sel_c.oor) data_in_d = sel_c.wdata;
          state_d     = ST_CMD;
        end
      end
      ST_CMD: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
    end
  end

  assign if_gnt   = if_win_c;
  assign d_gnt    = d_win_c;
  assign MemRead  = mem_read_q;
  assign MemWrite = mem_write_q;
  assign ADDR     = addr_q;
  assign Data_in  = data_in_q;

  // Response decoded from state; data only for in-range loads, zero otherwise.
  always_comb begin
    resp_c    = (state_q == ST_RESP);
    if_rvalid = resp_c & (owner_q == OWN_IF);
    d_rvalid  = resp_c & (owner_q == OWN_D);
    if_rdata  = (if_rvalid & ~oor_q) ? Data_out : '0;
    d_rdata   = (d_rvalid & ~oor_q & ~we_q) ? Data_out : '0;
    d_err     = d_rvalid & oor_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned SMAX  = 3;

  logic        CLK;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err;
  logic [15:0] if_rdata, d_rdata;
  logic        MemRead, MemWrite;
  logic [15:0] ADDR, Data_in, Data_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.MEM_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR),
    .Data_in(Data_in), .Data_out(Data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Default content of every memory word until written.
  function automatic logic [15:0] init_word(input logic [15:0] a);
    return 16'(32'(a) * 32'd40503 + 32'd7);
  endfunction

  // Memory model: samples the command on posedge, Data_out valid the next cycle.
  logic [15:0] mem    [0:1023];
  bit          mem_wr [0:1023];
  int          bad_cmd = 0;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0, bd_data = '0;

  always @(posedge CLK) begin
    if (bd_we) begin
      mem[bd_addr[9:0]]    <= bd_data;
      mem_wr[bd_addr[9:0]] <= 1'b1;
    end
    if (MemWrite === 1'b1) begin
      if (ADDR < 16'(DEPTH) && MemRead !== 1'b1) begin
        mem[ADDR[9:0]]    <= Data_in;
        mem_wr[ADDR[9:0]] <= 1'b1;
      end else begin
        bad_cmd <= bad_cmd + 1;
      end
    end
    if (MemRead === 1'b1) begin
      if (ADDR < 16'(DEPTH)) Data_out <= mem_wr[ADDR[9:0]] ? mem[ADDR[9:0]] : init_word(ADDR);
      else begin
        Data_out <= 16'hDEAD;
        bad_cmd  <= bad_cmd + 1;
      end
    end
  end

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem_wr[a[9:0]] ? mem[a[9:0]] : init_word(a);
  endfunction

  // Reference memory, updated only from the bench's view of accepted stores.
  logic [15:0] ref_mem [0:1023];
  bit          ref_wr  [0:1023];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (a >= 16'(DEPTH)) return 16'h0000;
    return ref_wr[a[9:0]] ? ref_mem[a[9:0]] : init_word(a);
  endfunction

  function automatic void ref_store(input logic [15:0] a, input logic [15:0] d);
    if (a < 16'(DEPTH)) begin
      ref_mem[a[9:0]] = d;
      ref_wr[a[9:0]]  = 1'b1;
    end
  endfunction

  typedef struct {
    bit          is_d;
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge CLK); #1;
    bd_we = 1'b0;
    ref_store(a, d);
  endtask

  // Drives one request and reports what was seen, offsets counted from the grant cycle.
  task automatic issue(input bit is_d, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata,
                       output int gnt_wait, output int rd_off, output int wr_off,
                       output int rv_off, output logic [15:0] rdata, output logic err,
                       output logic [15:0] cmd_addr, output bit stray);
    gnt_wait = -1; rd_off = -1; wr_off = -1; rv_off = -1;
    rdata = '0; err = 1'b0; cmd_addr = '0; stray = 1'b0;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if ((is_d ? d_gnt : if_gnt) === 1'b1) begin gnt_wait = c; break; end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    if_req = 1'b0; d_req = 1'b0;
    if (gnt_wait < 0) return;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (k == 1) cmd_addr = ADDR;
      if (MemRead === 1'b1 && rd_off < 0) rd_off = k;
      if (MemWrite === 1'b1 && wr_off < 0) wr_off = k;
      if ((is_d ? d_rvalid : if_rvalid) === 1'b1 && rv_off < 0) begin
        rv_off = k;
        rdata  = is_d ? d_rdata : if_rdata;
        err    = d_err;
      end
      if ((is_d ? if_rvalid : d_rvalid) === 1'b1) stray = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    #12;
    n_tests++; if ({MemRead, MemWrite} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {MemRead, MemWrite}); end
    n_tests++; if (ADDR !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", ADDR); end
    n_tests++; if (Data_in !== 16'h0) begin n_fail++; $display("FAIL reset_data_in: got %h expected 0000", Data_in); end
    n_tests++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, d_err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 00000", {if_gnt, d_gnt, if_rvalid, d_rvalid, d_err}); end
    n_tests++; if ({if_rdata, d_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata}); end
    #10 reset = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_tests++; if ({MemRead, MemWrite, if_rvalid, d_rvalid} !== 4'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0000", {MemRead, MemWrite, if_rvalid, d_rvalid}); end
    @(posedge CLK); #1;
  endtask

  task automatic test_if_read();
    int g, r, w, v; logic [15:0] rd, ca; logic e; bit s;
    bd_write(16'd5, 16'h2FE7);
    issue(1'b0, 1'b0, 16'd5, 16'h0, g, r, w, v, rd, e, ca, s);
    n_tests++; if (g !== 0) begin n_fail++; $display("FAIL if_gnt_wait: got %0d expected 0", g); end
    n_tests++; if (r !== 1 || ca !== 16'd5) begin n_fail++; $display("FAIL if_cmd: memread_off %0d addr %h expected 1 / 0005", r, ca); end
    n_tests++; if (w !== -1) begin n_fail++; $display("FAIL if_no_write: got off %0d expected -1", w); end
    n_tests++; if (v !== 2) begin n_fail++; $display("FAIL if_latency: got %0d expected 2", v); end
    n_tests++; if (rd !== 16'h2FE7) begin n_fail++; $display("FAIL if_rdata: got %h expected 2fe7", rd); end
    n_tests++; if (e !== 1'b0 || s !== 1'b0) begin n_fail++; $display("FAIL if_err_stray: err %b stray %b expected 0 0", e, s); end
  endtask

  task automatic test_store_load();
    int g, r, w, v; logic [15:0] rd, ca; logic e; bit s;
    issue(1'b1, 1'b1, 16'd30, 16'h0045, g, r, w, v, rd, e, ca, s);
    ref_store(16'd30, 16'h0045);
    n_tests++; if (g !== 0 || v !== 2) begin n_fail++; $display("FAIL st_timing: gnt %0d rvalid %0d expected 0 2", g, v); end
    n_tests++; if (w !== 1 || r !== -1) begin n_fail++; $display("FAIL st_strobes: wr_off %0d rd_off %0d expected 1 -1", w, r); end
    n_tests++; if (rd !== 16'h0 || e !== 1'b0) begin n_fail++; $display("FAIL st_resp: rdata %h err %b expected 0000 0", rd, e); end
    n_tests++; if (mem_rd(16'd30) !== ref_rd(16'd30)) begin n_fail++; $display("FAIL st_mem: got %h expected %h", mem_rd(16'd30), ref_rd(16'd30)); end
    issue(1'b1, 1'b0, 16'd30, 16'h0, g, r, w, v, rd, e, ca, s);
    n_tests++; if (r !== 1 || w !== -1) begin n_fail++; $display("FAIL ld_strobes: rd_off %0d wr_off %0d expected 1 -1", r, w); end
    n_tests++; if (rd !== ref_rd(16'd30) || e !== 1'b0 || v !== 2) begin n_fail++; $display("FAIL ld_resp: rdata %h err %b lat %0d expected %h 0 2", rd, e, v, ref_rd(16'd30)); end
  endtask

  task automatic test_oor();
    int g, r, w, v; logic [15:0] rd, ca; logic e; bit s;
    issue(1'b1, 1'b0, 16'd1024, 16'h0, g, r, w, v, rd, e, ca, s);
    n_tests++; if (r !== -1 || w !== -1) begin n_fail++; $display("FAIL oor_ld_strobes: rd %0d wr %0d expected -1 -1", r, w); end
    n_tests++; if (v !== 2 || e !== 1'b1 || rd !== 16'h0) begin n_fail++; $display("FAIL oor_ld_resp: lat %0d err %b rdata %h expected 2 1 0000", v, e, rd); end
    n_tests++; if (ca !== 16'd1024) begin n_fail++; $display("FAIL oor_addr: got %h expected 0400", ca); end
    issue(1'b1, 1'b1, 16'd1024, 16'h1234, g, r, w, v, rd, e, ca, s);
    n_tests++; if (r !== -1 || w !== -1 || e !== 1'b1 || rd !== 16'h0) begin n_fail++; $display("FAIL oor_st: rd %0d wr %0d err %b rdata %h expected -1 -1 1 0000", r, w, e, rd); end
    issue(1'b0, 1'b0, 16'hFFFF, 16'h0, g, r, w, v, rd, e, ca, s);
    n_tests++; if (r !== -1 || v !== 2 || rd !== 16'h0 || e !== 1'b0) begin n_fail++; $display("FAIL oor_if: rd %0d lat %0d rdata %h err %b expected -1 2 0000 0", r, v, rd, e); end
    issue(1'b1, 1'b0, 16'd1023, 16'h0, g, r, w, v, rd, e, ca, s);
    n_tests++; if (r !== 1 || rd !== ref_rd(16'd1023) || e !== 1'b0) begin n_fail++; $display("FAIL edge_1023: rd %0d rdata %h err %b expected 1 %h 0", r, rd, e, ref_rd(16'd1023)); end
    n_tests++; if (bad_cmd !== 0) begin n_fail++; $display("FAIL oor_reached_mem: got %0d expected 0", bad_cmd); end
  endtask

  // Both sides request continuously with random addresses; IF wins every (SMAX+1)th grant.
  task automatic test_starve();
    exp_t q[$];
    exp_t e;
    int cyc = 0, grants = 0, last_g = 0;
    bit gi, gd, exp_d;
    logic [15:0] obs;
    if_addr = 16'($urandom_range(0, 1100));
    d_we = 1'($urandom); d_addr = 16'($urandom_range(0, 1100)); d_wdata = 16'($urandom);
    if_req = 1'b1; d_req = 1'b1;
    while (cyc < 80 && (grants < 8 || q.size() > 0)) begin
      @(negedge CLK);
      gi = (if_gnt === 1'b1); gd = (d_gnt === 1'b1);
      if (gi && gd) begin n_tests++; n_fail++; $display("FAIL dual_gnt: both granted at cycle %0d", cyc); end
      else if (gi || gd) begin
        exp_d = (grants % (SMAX + 1)) != SMAX;
        n_tests++; if (gd !== exp_d) begin n_fail++; $display("FAIL grant_order[%0d]: got d=%b expected d=%b", grants, gd, exp_d); end
        if (grants > 0) begin
          n_tests++; if (cyc - last_g !== 3) begin n_fail++; $display("FAIL grant_spacing[%0d]: got %0d expected 3", grants, cyc - last_g); end
        end
        e.is_d = gd; e.due = cyc + 2;
        if (gd) begin
          e.err   = (d_addr >= 16'(DEPTH));
          e.rdata = (d_we || e.err) ? 16'h0 : ref_rd(d_addr);
          if (d_we) ref_store(d_addr, d_wdata);
        end else begin
          e.err = 1'b0; e.rdata = ref_rd(if_addr);
        end
        q.push_back(e);
        last_g = cyc; grants++;
      end
      if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
        obs = (d_rvalid === 1'b1) ? d_rdata : if_rdata;
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL stray_rvalid: cycle %0d", cyc); end
        else begin
          e = q.pop_front();
          if (d_rvalid !== e.is_d || obs !== e.rdata || d_err !== e.err || cyc !== e.due) begin
            n_fail++;
            $display("FAIL starve_resp: d=%b rdata %h err %b cyc %0d expected d=%b %h %b %0d",
                     d_rvalid, obs, d_err, cyc, e.is_d, e.rdata, e.err, e.due);
          end
        end
      end
      @(posedge CLK); #1;
      cyc++;
      if (grants >= 8) begin if_req = 1'b0; d_req = 1'b0; end
      else if (gi) if_addr = 16'($urandom_range(0, 1100));
      else if (gd) begin d_we = 1'($urandom); d_addr = 16'($urandom_range(0, 1100)); d_wdata = 16'($urandom); end
    end
    if_req = 1'b0; d_req = 1'b0;
    n_tests++; if (grants !== 8 || q.size() !== 0) begin n_fail++; $display("FAIL starve_done: grants %0d pending %0d expected 8 0", grants, q.size()); end
    n_tests++; if (bad_cmd !== 0) begin n_fail++; $display("FAIL starve_oor_mem: got %0d expected 0", bad_cmd); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, ng = 0, nr = 0;
    int gcyc [8];
    for (int i = 0; i < 8; i++) bd_write(16'(i), 16'($urandom));
    if_req = 1'b1; if_addr = 16'd0;
    while (cyc < 60 && nr < 8) begin
      @(negedge CLK);
      if (d_gnt === 1'b1) begin n_tests++; n_fail++; $display("FAIL b2b_d_gnt: cycle %0d", cyc); end
      if (if_gnt === 1'b1) begin
        if (ng >= 8) begin n_tests++; n_fail++; $display("FAIL b2b_extra_gnt: cycle %0d", cyc); end
        else begin
          gcyc[ng] = cyc;
          if (ng > 0) begin
            n_tests++; if (cyc - gcyc[ng-1] !== 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", ng, cyc - gcyc[ng-1]); end
          end
          ng++;
        end
      end
      if (if_rvalid === 1'b1) begin
        n_tests++;
        if (nr >= ng) begin n_fail++; $display("FAIL b2b_stray_rvalid: cycle %0d", cyc); end
        else if (if_rdata !== ref_rd(16'(nr)) || cyc !== gcyc[nr] + 2) begin
          n_fail++; $display("FAIL b2b_resp[%0d]: rdata %h cyc %0d expected %h %0d", nr, if_rdata, cyc, ref_rd(16'(nr)), gcyc[nr] + 2);
        end
        nr++;
      end
      @(posedge CLK); #1;
      cyc++;
      if (ng >= 8) if_req = 1'b0;
      else if_addr = 16'(ng);
    end
    if_req = 1'b0;
    n_tests++; if (ng !== 8 || nr !== 8) begin n_fail++; $display("FAIL b2b_count: gnts %0d resps %0d expected 8 8", ng, nr); end
  endtask

  task automatic test_reset_mid();
    int g, r, w, v; logic [15:0] rd, ca; logic e; bit s;
    bit rv_seen = 1'b0;
    logic [15:0] old = ref_rd(16'd40);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd40; d_wdata = ~old;
    @(negedge CLK);
    n_tests++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b expected 1", d_gnt); end
    @(posedge CLK); #1;
    d_req = 1'b0;
    @(negedge CLK);
    n_tests++; if (MemWrite !== 1'b1) begin n_fail++; $display("FAIL rm_cmd: MemWrite %b expected 1", MemWrite); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (MemWrite !== 1'b0 || ADDR !== 16'h0) begin n_fail++; $display("FAIL rm_async_clear: MemWrite %b ADDR %h expected 0 0000", MemWrite, ADDR); end
    repeat (3) begin
      @(negedge CLK);
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) rv_seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge CLK); #1;
    n_tests++; if (rv_seen !== 1'b0) begin n_fail++; $display("FAIL rm_rvalid: rvalid seen during reset, expected none"); end
    issue(1'b1, 1'b0, 16'd40, 16'h0, g, r, w, v, rd, e, ca, s);
    n_tests++; if (g !== 0 || v !== 2) begin n_fail++; $display("FAIL rm_fresh: gnt %0d lat %0d expected 0 2", g, v); end
    n_tests++; if (rd !== old) begin n_fail++; $display("FAIL rm_mem_unchanged: got %h expected %h", rd, old); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_read();
    test_store_load();
    test_oor();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
